// File: rtl/ak16_pkg.sv
// Shared definitions for the 16-bit pipelined CPU front end: data width,
// the NOP encoding presented when no instruction is available, the default
// reset fetch address and the {pc, instr} record carried by the prefetch queue.
package ak16_pkg;

    localparam int XLEN = 16;

    localparam logic [XLEN-1:0] NOP_INSTR        = 16'h0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Bundle of the prefetch queue's bus signals: the instruction memory
// request/grant/response channel, the redirect/halt controls from the
// pipeline and the valid/ready output channel towards IF/ID.
// The master modport is the prefetch queue itself; the slave modport is the
// surrounding environment (memory, branch unit and consumer).
interface if_prefetch_queue_if;
    import ak16_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            halt;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instr,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instr,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, halt, out_ready
    );

endinterface

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO of fetch entries used as the prefetch queue storage.
// Push and pop may happen together, even when full (the pop frees the slot
// the push fills). Clear empties the queue in a single cycle and wins over
// any push/pop in the same cycle. The head output is the raw slot contents;
// the caller decides what to show when count is zero.
module ifq_fifo
    import ak16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetch_entry_t           wdata,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear resets the queue to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage; slots are not reset because the count says which are live.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue in front of the IF stage.
// Issues in-order word fetches while queue slots plus in-flight fetches leave
// room (credit rule), tags each returned word with its PC, and presents the
// head entry over valid/ready. A redirect flushes the queue, reloads both PCs
// and arms a drop counter so responses to fetches issued before the redirect
// are swallowed as they come back. Halt only stops new requests.
// Optional build macro: IFQ_PERF_EN adds the perf_empty_cycles and
// perf_flushes saturating counters as extra output ports.
module if_prefetch_queue
    import ak16_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    if_prefetch_queue_if.master    bus
`ifdef IFQ_PERF_EN
    ,
    output logic [XLEN-1:0]        perf_empty_cycles,
    output logic [XLEN-1:0]        perf_flushes
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAX_OUT_W = CW'(MAX_OUTSTANDING);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop;
    logic [CW:0]     in_use;

    logic            req;
    logic            grant;
    logic            rsp;
    logic            accept;
    logic            out_valid;
    logic            pop;
    fetch_entry_t    wdata;
    fetch_entry_t    head;

    // Credits: a slot is reserved for every fetch in flight, so pushes never overflow.
    assign in_use = {1'b0, count} + {1'b0, outstanding};

    assign req = rst_n && !bus.halt && !bus.redirect
                 && (in_use < DEPTH_W) && (outstanding < MAX_OUT_W);

    assign grant  = req && bus.imem_gnt;
    assign rsp    = bus.imem_rvalid && (outstanding != '0);
    assign accept = rsp && (drop == '0) && !bus.redirect;

    assign outstanding_next = outstanding + CW'(grant) - CW'(rsp);

    assign out_valid = (count != '0) && !bus.redirect;
    assign pop       = out_valid && bus.out_ready;

    assign wdata.pc    = resp_pc;
    assign wdata.instr = bus.imem_rdata;

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = (count != '0) ? head.pc    : 16'h0000;
    assign bus.out_instr = (count != '0) ? head.instr : NOP_INSTR;

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop),
        .clear (bus.redirect),
        .wdata (wdata),
        .count (count),
        .head  (head)
    );

    // Fetch and response PCs advance on grant/accept and both reload on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            resp_pc  <= bus.redirect_pc;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 16'h0001;
            end
            if (accept) begin
                resp_pc <= resp_pc + 16'h0001;
            end
        end
    end

    // In-flight tracking; on redirect every fetch still out after this cycle becomes stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (bus.redirect) begin
                drop <= outstanding_next;
            end else if (rsp && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
        end
    end

`ifdef IFQ_PERF_EN
    // Saturating counters for starved cycles and pipeline flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_empty_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (!out_valid && !bus.halt && (perf_empty_cycles != 16'hFFFF)) begin
                perf_empty_cycles <= perf_empty_cycles + 16'h0001;
            end
            if (bus.redirect && (perf_flushes != 16'hFFFF)) begin
                perf_flushes <= perf_flushes + 16'h0001;
            end
        end
    end
`endif

endmodule
